network_rx_resp: RTL and testbench

Responder half of the vanilla tile's remote-memory protocol. It accepts incoming remote requests from the tile's endpoint and decodes the EPA into local DMEM, icache-write, or tile CSR space. It performs the access and returns exactly one response per request over a valid/ready return interface. It owns the tile config registers (freeze, tgo, cfg_pod) that the core and the tx path consume.

---
 rtl/network_rx_resp.sv | 197 +++++++++++++++++++
 tb/tb_network_rx_resp.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/network_rx_resp.sv
// Remote-request responder for the vanilla tile: decodes EPAs into DMEM, icache-write
// or CSR space, performs the access and returns one response per request.
module network_rx_resp #(
  parameter int data_width_p       = 32,
  parameter int addr_width_p       = 28,
  parameter int dmem_size_p        = 1024,
  parameter int icache_entries_p   = 1024,
  parameter int icache_tag_width_p = 12,
  parameter int num_tiles_x_p      = 16,
  parameter int num_tiles_y_p      = 8,
  parameter int pod_x_cord_width_p = 3,
  parameter int pod_y_cord_width_p = 4,
  localparam int dmem_aw_lp = $clog2(dmem_size_p),
  localparam int pc_w_lp    = icache_tag_width_p + $clog2(icache_entries_p),
  localparam int x_sub_lp   = $clog2(num_tiles_x_p),
  localparam int y_sub_lp   = $clog2(num_tiles_y_p)
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          in_v_i,
  input  logic                          in_we_i,
  input  logic [addr_width_p-1:0]       in_addr_i,
  input  logic [data_width_p-1:0]       in_data_i,
  input  logic [3:0]                    in_mask_i,
  output logic                          in_yumi_o,
  output logic                          returning_v_o,
  output logic [data_width_p-1:0]       returning_data_o,
  input  logic                          returning_ready_i,
  output logic                          dmem_v_o,
  output logic                          dmem_w_o,
  output logic [dmem_aw_lp-1:0]         dmem_addr_o,
  output logic [data_width_p-1:0]       dmem_data_o,
  output logic [3:0]                    dmem_mask_o,
  input  logic                          dmem_yumi_i,
  input  logic [data_width_p-1:0]       dmem_data_i,
  output logic                          icache_v_o,
  output logic [pc_w_lp-1:0]            icache_pc_o,
  output logic [data_width_p-1:0]       icache_instr_o,
  output logic                          freeze_o,
  output logic [x_sub_lp-1:0]           tgo_x_o,
  output logic [y_sub_lp-1:0]           tgo_y_o,
  output logic [pod_x_cord_width_p-1:0] cfg_pod_x_o,
  output logic [pod_y_cord_width_p-1:0] cfg_pod_y_o,
  output logic                          invalid_access_o
);

  typedef enum logic [1:0] {IDLE, DMEM_RESP, RESP} state_e;
  typedef enum logic [1:0] {REQ_DMEM, REQ_CSR, REQ_ICACHE, REQ_INVALID} req_e;

  state_e                          state_q, state_d;
  logic                            we_q, we_d;
  logic [data_width_p-1:0]         resp_data_q, resp_data_d;
  logic                            freeze_q, freeze_d;
  logic [x_sub_lp-1:0]             tgo_x_q, tgo_x_d;
  logic [y_sub_lp-1:0]             tgo_y_q, tgo_y_d;
  logic [pod_x_cord_width_p-1:0]   pod_x_q, pod_x_d;
  logic [pod_y_cord_width_p-1:0]   pod_y_q, pod_y_d;

  req_e                    req;
  logic [addr_width_p-1:0] csr_off;
  logic [data_width_p-1:0] csr_rdata;
  logic [data_width_p-1:0] dmem_resp;

  // Addresses below the CSR base wrap to large offsets and fall through to INVALID.
  assign csr_off = in_addr_i - addr_width_p'(32'h8000);

  always_comb begin
    if (in_addr_i[addr_width_p-1:dmem_aw_lp] == '0)  req = REQ_DMEM;
    else if (csr_off < addr_width_p'(5))            req = REQ_CSR;
    else if (in_addr_i[22])                          req = REQ_ICACHE;
    else                                             req = REQ_INVALID;
  end

  always_comb begin
    csr_rdata = '0;
    case (csr_off[2:0])
      3'd0:    csr_rdata = data_width_p'(freeze_q);
      3'd1:    csr_rdata = data_width_p'(tgo_x_q);
      3'd2:    csr_rdata = data_width_p'(tgo_y_q);
      3'd3:    csr_rdata = data_width_p'(pod_x_q);
      3'd4:    csr_rdata = data_width_p'(pod_y_q);
      default: csr_rdata = '0;
    endcase
  end

  assign dmem_w_o       = in_we_i;
  assign dmem_addr_o    = in_addr_i[dmem_aw_lp-1:0];
  assign dmem_data_o    = in_data_i;
  assign dmem_mask_o    = in_mask_i;
  assign icache_pc_o    = in_addr_i[pc_w_lp-1:0];
  assign icache_instr_o = in_data_i;
  assign dmem_resp      = we_q ? '0 : dmem_data_i;

  always_comb begin
    state_d          = state_q;
    we_d             = we_q;
    resp_data_d      = resp_data_q;
    freeze_d         = freeze_q;
    tgo_x_d          = tgo_x_q;
    tgo_y_d          = tgo_y_q;
    pod_x_d          = pod_x_q;
    pod_y_d          = pod_y_q;
    in_yumi_o        = 1'b0;
    returning_v_o    = 1'b0;
    returning_data_o = '0;
    dmem_v_o         = 1'b0;
    icache_v_o       = 1'b0;
    invalid_access_o = 1'b0;
    case (state_q)
      IDLE: if (in_v_i) begin
        case (req)
          REQ_DMEM: begin
            dmem_v_o  = 1'b1;
            in_yumi_o = dmem_yumi_i;
            if (dmem_yumi_i) begin
              we_d    = in_we_i;
              state_d = DMEM_RESP;
            end
          end
          REQ_CSR: begin
            in_yumi_o   = 1'b1;
            resp_data_d = in_we_i ? '0 : csr_rdata;
            state_d     = RESP;
            if (in_we_i) begin
              case (csr_off[2:0])
                3'd0:    freeze_d = in_data_i[0];
                3'd1:    tgo_x_d  = in_data_i[x_sub_lp-1:0];
                3'd2:    tgo_y_d  = in_data_i[y_sub_lp-1:0];
                3'd3:    pod_x_d  = in_data_i[pod_x_cord_width_p-1:0];
                3'd4:    pod_y_d  = in_data_i[pod_y_cord_width_p-1:0];
                default: ;
              endcase
            end
          end
          REQ_ICACHE: begin
            in_yumi_o        = 1'b1;
            icache_v_o       = in_we_i;
            invalid_access_o = ~in_we_i;
            resp_data_d      = '0;
            state_d          = RESP;
          end
          default: begin
            in_yumi_o        = 1'b1;
            invalid_access_o = 1'b1;
            resp_data_d      = '0;
            state_d          = RESP;
          end
        endcase
      end
      DMEM_RESP: begin
        // DMEM read data is only valid this cycle; park it if the return path stalls.
        returning_v_o    = 1'b1;
        returning_data_o = dmem_resp;
        if (returning_ready_i) state_d = IDLE;
        else begin
          resp_data_d = dmem_resp;
          state_d     = RESP;
        end
      end
      RESP: begin
        returning_v_o    = 1'b1;
        returning_data_o = resp_data_q;
        if (returning_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      resp_data_q <= '0;
      freeze_q    <= 1'b1;
      tgo_x_q     <= '0;
      tgo_y_q     <= '0;
      pod_x_q     <= '0;
      pod_y_q     <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      resp_data_q <= resp_data_d;
      freeze_q    <= freeze_d;
      tgo_x_q     <= tgo_x_d;
      tgo_y_q     <= tgo_y_d;
      pod_x_q     <= pod_x_d;
      pod_y_q     <= pod_y_d;
    end
  end

  assign freeze_o    = freeze_q;
  assign tgo_x_o     = tgo_x_q;
  assign tgo_y_o     = tgo_y_q;
  assign cfg_pod_x_o = pod_x_q;
  assign cfg_pod_y_o = pod_y_q;

endmodule

// File: tb/tb_network_rx_resp.sv
// Bench for network_rx_resp: table of requests with a behavioural DMEM and a
// response scoreboard, plus hand-written reset-during-response sequence.
module tb_network_rx_resp;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_v, in_we, in_yumi;
  logic [27:0] in_addr;
  logic [31:0] in_data;
  logic [3:0]  in_mask;
  logic        ret_v, ret_ready;
  logic [31:0] ret_data;
  logic        dmem_v, dmem_w, dmem_yumi;
  logic [9:0]  dmem_addr;
  logic [31:0] dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_mask;
  logic        icache_v;
  logic [21:0] icache_pc;
  logic [31:0] icache_instr;
  logic        freeze;
  logic [3:0]  tgo_x;
  logic [2:0]  tgo_y;
  logic [2:0]  pod_x;
  logic [3:0]  pod_y;
  logic        invalid;

  int unsigned tests = 0;
  int unsigned fails = 0;

  always #5 clk = ~clk;

  network_rx_resp #(.data_width_p(32), .addr_width_p(28), .dmem_size_p(1024)) dut (
    .clk_i(clk), .reset_i(reset),
    .in_v_i(in_v), .in_we_i(in_we), .in_addr_i(in_addr), .in_data_i(in_data),
    .in_mask_i(in_mask), .in_yumi_o(in_yumi),
    .returning_v_o(ret_v), .returning_data_o(ret_data), .returning_ready_i(ret_ready),
    .dmem_v_o(dmem_v), .dmem_w_o(dmem_w), .dmem_addr_o(dmem_addr), .dmem_data_o(dmem_wdata),
    .dmem_mask_o(dmem_mask), .dmem_yumi_i(dmem_yumi), .dmem_data_i(dmem_rdata),
    .icache_v_o(icache_v), .icache_pc_o(icache_pc), .icache_instr_o(icache_instr),
    .freeze_o(freeze), .tgo_x_o(tgo_x), .tgo_y_o(tgo_y),
    .cfg_pod_x_o(pod_x), .cfg_pod_y_o(pod_y), .invalid_access_o(invalid)
  );

  // External DMEM: read data appears the cycle after a grant, zero otherwise.
  logic [31:0] mem [1024];
  initial for (int i = 0; i < 1024; i++) mem[i] = '0;
  always @(posedge clk) begin
    if (dmem_v && dmem_yumi) begin
      dmem_rdata <= dmem_w ? 32'h0 : mem[dmem_addr];
      if (dmem_w)
        for (int b = 0; b < 4; b++)
          if (dmem_mask[b]) mem[dmem_addr][b*8 +: 8] <= dmem_wdata[b*8 +: 8];
    end else dmem_rdata <= 32'h0;
  end

  typedef struct {
    logic        we;
    logic [27:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
    int unsigned gd;
    int unsigned rd;
    logic [31:0] exp;
    logic        kd;
    logic        ki;
    logic        kv;
    logic        fz;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void add(input logic we, input logic [27:0] addr, input logic [31:0] data,
                              input logic [3:0] mask, input int unsigned gd, input int unsigned rd,
                              input logic [31:0] exp, input logic kd, input logic ki,
                              input logic kv, input logic fz);
    vec_t v;
    v.we = we; v.addr = addr; v.data = data; v.mask = mask; v.gd = gd; v.rd = rd;
    v.exp = exp; v.kd = kd; v.ki = ki; v.kv = kv; v.fz = fz;
    vecs.push_back(v);
  endfunction

  task automatic run_vec(input vec_t v);
    logic [31:0] e;
    @(negedge clk);
    in_v = 1'b1; in_we = v.we; in_addr = v.addr; in_data = v.data; in_mask = v.mask;
    dmem_yumi = 1'b0; ret_ready = 1'b0;
    for (int i = 0; i < int'(v.gd); i++) begin
      #1;
      chk("stall_yumi", 32'(in_yumi), 32'd0);
      chk("stall_dmem_v", 32'(dmem_v), 32'd1);
      @(negedge clk);
    end
    dmem_yumi = 1'b1;
    #1;
    chk("yumi", 32'(in_yumi), 32'd1);
    chk("dmem_v", 32'(dmem_v), 32'(v.kd));
    chk("icache_v", 32'(icache_v), 32'(v.ki));
    chk("invalid", 32'(invalid), 32'(v.kv));
    if (v.kd) begin
      chk("dmem_w", 32'(dmem_w), 32'(v.we));
      chk("dmem_addr", 32'(dmem_addr), 32'(v.addr[9:0]));
      chk("dmem_data", dmem_wdata, v.data);
      chk("dmem_mask", 32'(dmem_mask), 32'(v.mask));
    end
    if (v.ki) begin
      chk("icache_pc", 32'(icache_pc), 32'(v.addr[21:0]));
      chk("icache_instr", icache_instr, v.data);
    end
    sb.push_back(v.exp);
    @(negedge clk);
    in_v = 1'b0; dmem_yumi = 1'b0;
    for (int i = 0; i < int'(v.rd); i++) begin
      #1;
      chk("hold_v", 32'(ret_v), 32'd1);
      chk("hold_data", ret_data, (sb.size() > 0) ? sb[0] : 32'hx);
      chk("no_invalid_hold", 32'(invalid), 32'd0);
      @(negedge clk);
    end
    ret_ready = 1'b1;
    #1;
    chk("resp_v", 32'(ret_v), 32'd1);
    if (sb.size() == 0) chk("sb_empty", 32'd1, 32'd0);
    else begin
      e = sb.pop_front();
      chk("resp_data", ret_data, e);
    end
    @(negedge clk);
    ret_ready = 1'b0;
    #1;
    chk("idle_v", 32'(ret_v), 32'd0);
    chk("freeze", 32'(freeze), 32'(v.fz));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_v = 1'b0; in_we = 1'b0; in_addr = '0; in_data = '0; in_mask = '0;
    dmem_yumi = 1'b0; ret_ready = 1'b0;

    //  we  addr         data          mask gd rd exp           kd ki kv fz
    add(1, 28'h0000010, 32'hDEADBEEF, 4'hF, 0, 0, 32'h0,        1, 0, 0, 1);
    add(0, 28'h0000010, 32'h0,        4'hF, 3, 2, 32'hDEADBEEF, 1, 0, 0, 1);
    add(1, 28'h00003FF, 32'h11223344, 4'h5, 1, 0, 32'h0,        1, 0, 0, 1);
    add(0, 28'h00003FF, 32'h0,        4'hF, 0, 1, 32'h00220044, 1, 0, 0, 1);
    add(1, 28'h0008000, 32'h0,        4'hF, 0, 0, 32'h0,        0, 0, 0, 0);
    add(0, 28'h0008000, 32'h0,        4'hF, 0, 0, 32'h0,        0, 0, 0, 0);
    add(1, 28'h0008000, 32'h3,        4'h0, 0, 0, 32'h0,        0, 0, 0, 1);
    add(0, 28'h0008000, 32'h0,        4'hF, 0, 2, 32'h1,        0, 0, 0, 1);
    add(1, 28'h0008000, 32'h2,        4'hF, 0, 0, 32'h0,        0, 0, 0, 0);
    add(1, 28'h0008001, 32'hA,        4'hF, 0, 0, 32'h0,        0, 0, 0, 0);
    add(0, 28'h0008001, 32'h0,        4'hF, 0, 0, 32'hA,        0, 0, 0, 0);
    add(1, 28'h0008002, 32'hFFFFFFF5, 4'hF, 0, 0, 32'h0,        0, 0, 0, 0);
    add(0, 28'h0008002, 32'h0,        4'hF, 0, 0, 32'h5,        0, 0, 0, 0);
    add(1, 28'h0008003, 32'h6,        4'h0, 0, 0, 32'h0,        0, 0, 0, 0);
    add(0, 28'h0008003, 32'h0,        4'hF, 0, 0, 32'h6,        0, 0, 0, 0);
    add(1, 28'h0008004, 32'hB,        4'hF, 0, 1, 32'h0,        0, 0, 0, 0);
    add(0, 28'h0008004, 32'h0,        4'hF, 0, 0, 32'hB,        0, 0, 0, 0);
    add(1, 28'h0400005, 32'h00000013, 4'hF, 0, 0, 32'h0,        0, 1, 0, 0);
    add(0, 28'h0400005, 32'h0,        4'hF, 0, 0, 32'h0,        0, 0, 1, 0);
    add(0, 28'h1000000, 32'h0,        4'hF, 0, 0, 32'h0,        0, 0, 1, 0);
    add(0, 28'h0008005, 32'h0,        4'hF, 0, 0, 32'h0,        0, 0, 1, 0);
    add(1, 28'h0000400, 32'h12345678, 4'hF, 0, 1, 32'h0,        0, 0, 1, 0);

    repeat (2) @(negedge clk);
    #1;
    chk("rst_freeze", 32'(freeze), 32'd1);
    chk("rst_tgo_x", 32'(tgo_x), 32'd0);
    chk("rst_tgo_y", 32'(tgo_y), 32'd0);
    chk("rst_ret_v", 32'(ret_v), 32'd0);
    chk("rst_dmem_v", 32'(dmem_v), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    #1;
    chk("tgo_x", 32'(tgo_x), 32'hA);
    chk("tgo_y", 32'(tgo_y), 32'h5);
    chk("pod_x", 32'(pod_x), 32'h6);
    chk("pod_y", 32'(pod_y), 32'hB);
    chk("mem_3ff", mem[10'h3FF], 32'h00220044);
    chk("mem_10", mem[10'h010], 32'hDEADBEEF);

    // Reset while a CSR load response is pending: the response is dropped.
    @(negedge clk);
    in_v = 1'b1; in_we = 1'b0; in_addr = 28'h0008001; ret_ready = 1'b0;
    #1;
    chk("pre_rst_yumi", 32'(in_yumi), 32'd1);
    @(negedge clk);
    in_v = 1'b0;
    #1;
    chk("pre_rst_v", 32'(ret_v), 32'd1);
    chk("pre_rst_data", ret_data, 32'hA);
    reset = 1'b1;
    #1;
    chk("mid_rst_v", 32'(ret_v), 32'd0);
    chk("mid_rst_freeze", 32'(freeze), 32'd1);
    chk("mid_rst_tgo_x", 32'(tgo_x), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_rst_v", 32'(ret_v), 32'd0);

    begin
      vec_t v;
      v.we = 0; v.addr = 28'h0000010; v.data = 0; v.mask = 4'hF; v.gd = 1; v.rd = 0;
      v.exp = 32'hDEADBEEF; v.kd = 1; v.ki = 0; v.kv = 0; v.fz = 1;
      run_vec(v);
      v.addr = 28'h0008001; v.gd = 0; v.exp = 32'h0; v.kd = 0;
      run_vec(v);
    end

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
